// File: rtl/sync_fifo_buf.sv
// rtl/sync_fifo_buf.sv - single-clock FIFO with registered read port, thresholds, sticky errors; optional parity via SYNC_FIFO_PARITY_EN
module sync_fifo_buf #(
    parameter int D_SIZE  = 16,
    parameter int F_DEPTH = 8,
    parameter int P_SIZE  = 4,
    parameter int AF_THR  = 6,
    parameter int AE_THR  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_inc,
    input  logic [D_SIZE-1:0] w_data,
`ifdef SYNC_FIFO_PARITY_EN
    input  logic              w_par_inv,
    output logic              par_err,
`endif
    input  logic              r_inc,
    output logic [D_SIZE-1:0] r_data,
    output logic              r_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [P_SIZE-1:0] count,
    output logic              overflow,
    output logic              underflow
);

    // Stored word width: parity build carries one extra bit above the data.
`ifdef SYNC_FIFO_PARITY_EN
    localparam int M_SIZE = D_SIZE + 1;
`else
    localparam int M_SIZE = D_SIZE;
`endif
    localparam int A_SIZE = P_SIZE - 1;

    // Thresholds cast once so every compare runs at count width.
    localparam logic [P_SIZE-1:0] AF_LVL = P_SIZE'(AF_THR);
    localparam logic [P_SIZE-1:0] AE_LVL = P_SIZE'(AE_THR);
    localparam logic [P_SIZE-1:0] ONE    = P_SIZE'(1);

    logic [M_SIZE-1:0] mem [F_DEPTH];
    logic [P_SIZE-1:0] w_ptr;
    logic [P_SIZE-1:0] r_ptr;
    logic [A_SIZE-1:0] w_addr;
    logic [A_SIZE-1:0] r_addr;
    logic              wr_en;
    logic              rd_en;
    logic [M_SIZE-1:0] wr_word;
    logic [M_SIZE-1:0] rd_word;

    assign w_addr = w_ptr[A_SIZE-1:0];
    assign r_addr = r_ptr[A_SIZE-1:0];

    // Flags come straight from the pointer pair, so they track count in the same cycle.
    always_comb begin
        empty = (w_ptr == r_ptr);
        full  = (w_ptr[P_SIZE-1] != r_ptr[P_SIZE-1]) &&
                (w_ptr[A_SIZE-1:0] == r_ptr[A_SIZE-1:0]);
    end

    // Threshold flags follow the registered occupancy.
    always_comb begin
        almost_full  = (count >= AF_LVL);
        almost_empty = (count <= AE_LVL);
    end

    // Accept qualification uses the pre-edge flags; rejected requests are ignored.
    always_comb begin
        wr_en = w_inc && !full;
        rd_en = r_inc && !empty;
    end

    // Build the word to store, with even parity (optionally inverted) on top.
    always_comb begin
`ifdef SYNC_FIFO_PARITY_EN
        wr_word = {(^w_data) ^ w_par_inv, w_data};
`else
        wr_word = w_data;
`endif
    end

    assign rd_word = mem[r_addr];

    // Storage array: written on accepted writes only, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[w_addr] <= wr_word;
        end
    end

    // Pointers advance on accept and wrap naturally through the extra bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (wr_en) begin
                w_ptr <= w_ptr + ONE;
            end
            if (rd_en) begin
                r_ptr <= r_ptr + ONE;
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Registered read port: data holds between pops, valid pulses for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= rd_en;
            if (rd_en) begin
                r_data <= rd_word[D_SIZE-1:0];
            end
        end
    end

    // Sticky error flags: any attempt against the wrong boundary, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_inc && full) begin
                overflow <= 1'b1;
            end
            if (r_inc && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_PARITY_EN
    // Parity check on the popped word, aligned with r_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= rd_en && ((^rd_word[D_SIZE-1:0]) != rd_word[D_SIZE]);
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_buf.sv
// tb/tb_sync_fifo_buf.sv - directed and random bench for sync_fifo_buf against a queue model
module tb_sync_fifo_buf;

    localparam int D     = 16;
    localparam int DEPTH = 8;
    localparam int P     = 4;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         w_inc = 1'b0;
    logic [D-1:0] w_data = '0;
    logic         r_inc = 1'b0;
    logic [D-1:0] r_data;
    logic         r_valid;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [P-1:0] count;
    logic         overflow;
    logic         underflow;
`ifdef SYNC_FIFO_PARITY_EN
    logic         w_par_inv = 1'b0;
    logic         par_err;
`endif

    sync_fifo_buf #(
        .D_SIZE(D), .F_DEPTH(DEPTH), .P_SIZE(P), .AF_THR(AF), .AE_THR(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .w_inc(w_inc),
        .w_data(w_data),
`ifdef SYNC_FIFO_PARITY_EN
        .w_par_inv(w_par_inv),
        .par_err(par_err),
`endif
        .r_inc(r_inc),
        .r_data(r_data),
        .r_valid(r_valid),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queue of {parity-inverted flag, data}
    logic [D:0]   q[$];
    logic [D-1:0] m_rdata = '0;
    logic         m_rvalid = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;
    logic         m_perr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q.size();
        chk({tag, ":count"},  32'(count),        32'(sz));
        chk({tag, ":empty"},  32'(empty),        32'(sz == 0));
        chk({tag, ":full"},   32'(full),         32'(sz == DEPTH));
        chk({tag, ":afull"},  32'(almost_full),  32'(sz >= AF));
        chk({tag, ":aempty"}, 32'(almost_empty), 32'(sz <= AE));
        chk({tag, ":rvalid"}, 32'(r_valid),      32'(m_rvalid));
        chk({tag, ":rdata"},  32'(r_data),       32'(m_rdata));
        chk({tag, ":ovf"},    32'(overflow),     32'(m_ovf));
        chk({tag, ":unf"},    32'(underflow),    32'(m_unf));
`ifdef SYNC_FIFO_PARITY_EN
        chk({tag, ":perr"},   32'(par_err),      32'(m_perr));
`endif
    endtask

    // One clock: drive inputs at negedge, update model at posedge, check 1 time unit later.
    task automatic step(input string tag, input logic rs, input logic w, input logic [D-1:0] d,
                        input logic r, input logic pinv);
        logic [D:0] e;
        bit was_full;
        bit was_empty;
        @(negedge clk);
        rst    = rs;
        w_inc  = w;
        w_data = d;
        r_inc  = r;
`ifdef SYNC_FIFO_PARITY_EN
        w_par_inv = pinv;
`endif
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_rdata = '0; m_rvalid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_perr = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            m_rvalid = 1'b0;
            m_perr   = 1'b0;
            if (r && !was_empty) begin
                e = q.pop_front();
                m_rdata  = e[D-1:0];
                m_rvalid = 1'b1;
`ifdef SYNC_FIFO_PARITY_EN
                m_perr   = e[D];
`endif
            end
            if (w && !was_full) q.push_back({pinv, d});
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset state
        step("reset", 1, 0, 16'h0, 0, 0);
        step("reset2", 1, 0, 16'h0, 0, 0);
        step("idle", 0, 0, 16'h0, 0, 0);

        // Fill 1..8, then rejected 9th write
        for (int i = 1; i <= 8; i++) step("fill", 0, 1, D'(i), 0, 0);
        step("ovf_write", 0, 1, 16'hDEAD, 0, 0);

        // Drain 8, then rejected read
        for (int i = 0; i < 8; i++) step("drain", 0, 0, 16'h0, 1, 0);
        step("idle_after_drain", 0, 0, 16'h0, 0, 0);
        step("unf_read", 0, 0, 16'h0, 1, 0);

        // Steady state at count=4 with simultaneous push/pop, pointers wrap
        step("rst_b", 1, 0, 16'h0, 0, 0);
        for (int i = 0; i < 4; i++) step("pre4", 0, 1, D'(16'h0100 + i), 0, 0);
        for (int i = 0; i < 20; i++) step("both4", 0, 1, 16'h00AA, 1, 0);

        // Full + write + read: read wins
        for (int i = 0; i < 4; i++) step("to_full", 0, 1, D'(16'h0200 + i), 0, 0);
        step("full_both", 0, 1, 16'hBEEF, 1, 0);

        // Empty + write + read: write wins, no bypass
        step("rst_c", 1, 0, 16'h0, 0, 0);
        step("empty_both", 0, 1, 16'h1234, 1, 0);
        step("read_1234", 0, 0, 16'h0, 1, 0);
        step("idle_c", 0, 0, 16'h0, 0, 0);

        // Reset mid-stream at count=5 with r_inc high, after provoking both sticky flags
        step("unf_c", 0, 0, 16'h0, 1, 0);
        for (int i = 0; i < 8; i++) step("fill_c", 0, 1, D'(16'h0300 + i), 0, 0);
        step("ovf_c", 0, 1, 16'h0, 0, 0);
        for (int i = 0; i < 3; i++) step("to5", 0, 0, 16'h0, 1, 0);
        step("rst_mid", 1, 0, 16'h0, 1, 0);
        step("after_rst", 0, 0, 16'h0, 0, 0);

`ifdef SYNC_FIFO_PARITY_EN
        step("par_w_bad", 0, 1, 16'h0F0F, 0, 1);
        step("par_w_ok",  0, 1, 16'h0F0E, 0, 0);
        step("par_r_bad", 0, 0, 16'h0, 1, 0);
        step("par_r_ok",  0, 0, 16'h0, 1, 0);
        step("par_idle",  0, 0, 16'h0, 0, 0);
`endif

        // Randomized traffic with biased write/read rates
        for (int i = 0; i < 400; i++) begin
            logic w, r, pv;
            int bias;
            bias = (i / 50) % 4;
            w  = ($urandom_range(0, 3) < bias + 1) ? 1'b1 : 1'b0;
            r  = ($urandom_range(0, 3) < 4 - bias) ? 1'b1 : 1'b0;
            pv = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
            step("rand", ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, w, D'($urandom), r, pv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_buf.md
Name: sync_fifo_buf

Overview:
- Single-clock, parametrised FIFO buffer: storage, read/write pointers, occupancy counter and status flags in one block.
- Successor to the dual-port FIFO memory. Used where producer and consumer share one clock, e.g. the register-file/ALU path and the UART TX staging buffer.
- Adds over the plain memory: registered read port with a valid strobe, programmable almost-full/almost-empty thresholds, occupancy count, sticky overflow/underflow, and optional per-word parity.

Parameters:
- D_SIZE, 16: data word width in bits (>=1).
- F_DEPTH, 8: number of entries; power of two, >=2.
- P_SIZE, 4: pointer width, log2(F_DEPTH)+1. The extra bit is the wrap bit.
- AF_THR, 6: almost_full threshold; 1 <= AF_THR <= F_DEPTH.
- AE_THR, 2: almost_empty threshold; 0 <= AE_THR < F_DEPTH.

Ports:
- clk  input  1  operating clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- w_inc  input  1  write request.
- w_data  input  D_SIZE  write data.
- r_inc  input  1  read request.
- r_data  output  D_SIZE  registered read data.
- r_valid  output  1  one-cycle strobe: r_data holds a newly popped word.
- full  output  1  FIFO holds F_DEPTH words.
- empty  output  1  FIFO holds 0 words.
- almost_full  output  1  count >= AF_THR.
- almost_empty  output  1  count <= AE_THR.
- count  output  P_SIZE  current occupancy, 0..F_DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-high (rst sampled on the rising edge of clk).
- Reset values: w_ptr=0, r_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, r_data=0, r_valid=0, overflow=0, underflow=0. Memory array is not reset; contents are don't-care until written.
- Reset mid-operation discards all stored words. The first post-reset read of an unwritten location cannot occur because empty=1.
- Write accept: w_inc && !full, using full as sampled before the edge. mem[w_ptr[P_SIZE-2:0]] <= w_data; w_ptr increments modulo 2^P_SIZE.
- Read accept: r_inc && !empty. r_data <= mem[r_ptr[P_SIZE-2:0]]; r_ptr increments; r_valid=1 in the next cycle only.
  - Latency: one clock from accepted r_inc to r_data/r_valid.
  - r_data holds its last value when no read is accepted.
- Simultaneous accepted write and read: count unchanged, both pointers advance.
  - Full + w_inc + r_inc: read accepted, write rejected.
  - Empty + w_inc + r_inc: write accepted, read rejected. No write-to-read bypass.
- count: +1 on write only, -1 on read only, else hold. Never exceeds F_DEPTH and never wraps below 0.
- Flags:
  - empty = (w_ptr == r_ptr).
  - full = MSBs differ and lower P_SIZE-1 bits equal.
  - Both flags are registered-consistent with count in the same cycle.
- almost_full / almost_empty are derived from the registered count and change in the same cycle as count.
- overflow is set on w_inc && full; underflow is set on r_inc && empty. Both are cleared only by rst. Rejected requests change no other state.
- Pointer wrap: after 2^P_SIZE total accepted operations a pointer returns to 0 with no discontinuity in data order.

Optional Feature:
- Macro: SYNC_FIFO_PARITY_EN.
- Defined:
  - Each entry stores D_SIZE+1 bits: data plus an even-parity bit (XOR of w_data).
  - On an accepted read, parity is recomputed from the stored data and compared with the stored bit.
  - Added output par_err (1 bit): asserted together with r_valid for that word on mismatch; reset 0.
  - Added input w_par_inv (1 bit): inverts the stored parity bit of the word being written, for error injection.
- Not defined: memory is D_SIZE wide; par_err and w_par_inv do not exist.

Test Plan:
- Reset, then write 0x0001..0x0008 on 8 consecutive cycles -> full=1, count=8, almost_full first asserted after the 6th write. A 9th write of 0xDEAD is rejected -> overflow=1, count stays 8.
- Read 8 words from full -> r_data sequence 0x0001..0x0008, each one cycle after r_inc with r_valid=1. Then empty=1, almost_empty=1, count=0. A further r_inc -> underflow=1, r_data stays 0x0008.
- At count=4, assert w_inc (0x00AA) and r_inc together for 20 cycles -> count constant at 4. Pointers wrap past 2^P_SIZE; output order matches input order exactly.
- Full + w_inc(0xBEEF) + r_inc in the same cycle -> oldest word popped, 0xBEEF not stored, count=7, full=0.
- Empty + w_inc(0x1234) + r_inc -> no r_valid, count=1. The next cycle's read returns 0x1234.
- Assert rst mid-stream at count=5 with r_inc high -> next cycle: count=0, empty=1, r_valid=0, overflow/underflow cleared. With SYNC_FIFO_PARITY_EN: write 0x0F0F with w_par_inv=1, read it back -> par_err=1 alongside r_valid; a normal write/read gives par_err=0.
